// File: rtl/pool_window_gen_if.sv
// Handshake bundle between the activation stream, the 2x2 window generator and the pooling comparator.
// The slave view belongs to the window generator, the master view to whatever drives and drains it.
interface pool_window_gen_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              win_valid;
  logic              win_ready;
  logic [DATA_W-1:0] win0;
  logic [DATA_W-1:0] win1;
  logic [DATA_W-1:0] win2;
  logic [DATA_W-1:0] win3;
  logic              win_last;

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win0, win1, win2, win3, win_last
  );

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win0, win1, win2, win3, win_last
  );
endinterface

// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window generator: buffers one even row, then emits a window on every
// odd column of the following odd row through a single output register with valid/ready.
module pool_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input logic              clk,
  input logic              rst,
  pool_window_gen_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {
    FILL = 1'b0,
    POOL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] win0_q, win0_d;
  logic [DATA_W-1:0] win1_q, win1_d;
  logic [DATA_W-1:0] win2_q, win2_d;
  logic [DATA_W-1:0] win3_q, win3_d;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;
  logic [DATA_W-1:0] lb [IMG_W];

  logic          accept;
  logic          col_wrap;
  logic          row_wrap;
  logic          load;
  logic [CW-1:0] col_even;

  // A full output register stalls every input pixel, not only the ones that would load it.
  assign bus.in_ready = ~win_valid_q | bus.win_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign col_wrap     = (col_q == CW'(IMG_W - 1));
  assign row_wrap     = (row_q == RW'(IMG_H - 1));
  assign load         = accept & (state_q == POOL) & col_q[0];
  assign col_even     = col_q & ~CW'(1);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    win0_d      = win0_q;
    win1_d      = win1_q;
    win2_d      = win2_q;
    win3_d      = win3_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (accept) begin
      col_d = col_wrap ? '0 : col_q + CW'(1);
      if (col_wrap) begin
        row_d   = row_wrap ? '0 : row_q + RW'(1);
        state_d = (state_q == FILL) ? POOL : FILL;
      end
      if ((state_q == POOL) && !col_q[0]) begin
        hold_d = bus.in_data;
      end
    end

    // A load wins over a simultaneous drain, so valid stays high with the new window.
    if (load) begin
      win0_d      = lb[col_even];
      win1_d      = lb[col_q];
      win2_d      = hold_q;
      win3_d      = bus.in_data;
      win_last_d  = row_wrap & col_wrap;
      win_valid_d = 1'b1;
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      win0_q      <= '0;
      win1_q      <= '0;
      win2_q      <= '0;
      win3_q      <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      win0_q      <= win0_d;
      win1_q      <= win1_d;
      win2_q      <= win2_d;
      win3_q      <= win3_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  // NOTE: the line buffer has no reset; every entry is written in FILL before POOL reads it.
  always_ff @(posedge clk) begin
    if (accept && (state_q == FILL)) begin
      lb[col_q] <= bus.in_data;
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win0      = win0_q;
  assign bus.win1      = win1_q;
  assign bus.win2      = win2_q;
  assign bus.win3      = win3_q;
  assign bus.win_last  = win_last_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: a 4x4 instance for the frame-level scenarios and an 8x8
// instance for the irregular-handshake run, each window compared against hand-derived values.
module tb_pool_window_gen;
  typedef struct packed {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] w3;
    logic        last;
  } win_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  win_t q_a[$];
  win_t q_b[$];

  pool_window_gen_if #(.DATA_W(16)) bus_a ();
  pool_window_gen_if #(.DATA_W(16)) bus_b ();

  pool_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pool_window_gen #(.DATA_W(16), .IMG_W(8), .IMG_H(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Windows are recorded at the falling edge, when the handshake about to complete is stable.
  always @(negedge clk) begin
    if (bus_a.win_valid === 1'b1 && bus_a.win_ready === 1'b1)
      q_a.push_back({bus_a.win0, bus_a.win1, bus_a.win2, bus_a.win3, bus_a.win_last});
    if (bus_b.win_valid === 1'b1 && bus_b.win_ready === 1'b1)
      q_b.push_back({bus_b.win0, bus_b.win1, bus_b.win2, bus_b.win3, bus_b.win_last});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int d);
    logic acc;
    acc = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 16'(d);
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = bus_a.in_ready;
      step();
    end
    if (!acc) check("send_a_accept", {63'd0, acc}, 64'd1);
  endtask

  function automatic logic [15:0] pix_b(input int i);
    return 16'(i * 1237 - 30000);
  endfunction

  task automatic send_b(input int i);
    logic acc;
    repeat ($urandom_range(0, 2)) begin
      bus_b.in_valid  = 1'b0;
      bus_b.win_ready = 1'($urandom_range(0, 1));
      step();
    end
    acc = 1'b0;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = pix_b(i);
    for (int n = 0; n < 100 && !acc; n++) begin
      bus_b.win_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus_b.in_ready;
      step();
    end
    if (!acc) check("send_b_accept", {63'd0, acc}, 64'd1);
  endtask

  // Checks the recorded windows of n_frames consecutive 4x4 frames whose first pixel is base.
  task automatic check_q_4x4(input string tag, input int base, input int n_frames);
    int r, c, b;
    check({tag, "_count"}, 64'(q_a.size()), 64'(4 * n_frames));
    for (int k = 0; k < q_a.size() && k < 4 * n_frames; k++) begin
      r = (k % 4) / 2;
      c = k % 2;
      b = base + 16 * (k / 4) + 8 * r + 2 * c;
      check($sformatf("%s_win%0d", tag, k), {q_a[k].w0, q_a[k].w1, q_a[k].w2, q_a[k].w3},
            {16'(b), 16'(b + 1), 16'(b + 4), 16'(b + 5)});
      check($sformatf("%s_last%0d", tag, k), {63'd0, q_a[k].last}, {63'd0, (k % 4) == 3});
    end
  endtask

  initial begin
    int i0, r, c, t0;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.win_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.win_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_win_valid", {63'd0, bus_a.win_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
    check("rst_words", {bus_a.win0, bus_a.win1, bus_a.win2, bus_a.win3}, 64'd0);
    check("rst_last", {63'd0, bus_a.win_last}, 64'd0);
    rst = 1'b1;
    step();

    // 4x4 frame 0..15, free-flowing: window visible the cycle after its bottom-right pixel
    q_a.delete();
    for (int i = 0; i < 16; i++) begin
      send_a(i);
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        check($sformatf("flow_valid_p%0d", i), {63'd0, bus_a.win_valid}, 64'd1);
        check($sformatf("flow_words_p%0d", i), {bus_a.win0, bus_a.win1, bus_a.win2, bus_a.win3},
              {16'(i - 5), 16'(i - 4), 16'(i - 1), 16'(i)});
        check($sformatf("flow_last_p%0d", i), {63'd0, bus_a.win_last}, {63'd0, i == 15});
      end else begin
        check($sformatf("flow_idle_p%0d", i), {63'd0, bus_a.win_valid}, 64'd0);
      end
    end
    bus_a.in_valid = 1'b0;
    step();
    check_q_4x4("flow", 0, 1);

    // Backpressure: first window held for 5 cycles, input stalled
    q_a.delete();
    bus_a.win_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_a(i);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 16'd6;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_valid_c%0d", k), {63'd0, bus_a.win_valid}, 64'd1);
      check($sformatf("bp_in_ready_c%0d", k), {63'd0, bus_a.in_ready}, 64'd0);
      check($sformatf("bp_words_c%0d", k), {bus_a.win0, bus_a.win1, bus_a.win2, bus_a.win3},
            {16'd0, 16'd1, 16'd4, 16'd5});
      check($sformatf("bp_last_c%0d", k), {63'd0, bus_a.win_last}, 64'd0);
      step();
    end
    bus_a.win_ready = 1'b1;
    for (int i = 6; i < 16; i++) send_a(i);
    bus_a.in_valid = 1'b0;
    step();
    step();
    check_q_4x4("bp", 0, 1);

    // Signed extremes in the first 2x2 block pass bit-exact
    q_a.delete();
    for (int i = 0; i < 16; i++) begin
      i0 = (i == 0) ? -32768 : (i == 1) ? 32767 : (i == 4) ? -1 : (i == 5) ? 0 : i;
      send_a(i0);
    end
    bus_a.in_valid = 1'b0;
    step();
    check("signed_count", 64'(q_a.size()), 64'd4);
    if (q_a.size() > 0) begin
      check("signed_words", {q_a[0].w0, q_a[0].w1, q_a[0].w2, q_a[0].w3},
            {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000});
      check("signed_last", {63'd0, q_a[0].last}, 64'd0);
    end

    // 8x8 frame with random input gaps and random downstream ready
    q_b.delete();
    for (int i = 0; i < 64; i++) send_b(i);
    bus_b.in_valid = 1'b0;
    for (int n = 0; n < 200 && q_b.size() < 16; n++) begin
      bus_b.win_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus_b.win_ready = 1'b1;
    step();
    step();
    check("rand_count", 64'(q_b.size()), 64'd16);
    check("rand_drained", {63'd0, bus_b.win_valid}, 64'd0);
    for (int k = 0; k < q_b.size() && k < 16; k++) begin
      r  = k / 4;
      c  = k % 4;
      i0 = 16 * r + 2 * c;
      check($sformatf("rand_win%0d", k), {q_b[k].w0, q_b[k].w1, q_b[k].w2, q_b[k].w3},
            {pix_b(i0), pix_b(i0 + 1), pix_b(i0 + 8), pix_b(i0 + 9)});
      check($sformatf("rand_last%0d", k), {63'd0, q_b[k].last}, {63'd0, k == 15});
    end

    // Reset mid-frame with a window pending: it must never be delivered
    q_a.delete();
    bus_a.win_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_a(i);
    bus_a.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_valid", {63'd0, bus_a.win_valid}, 64'd0);
    check("abort_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
    check("abort_words", {bus_a.win0, bus_a.win1, bus_a.win2, bus_a.win3}, 64'd0);
    step();
    step();
    rst = 1'b1;
    bus_a.win_ready = 1'b1;
    step();
    for (int i = 100; i < 116; i++) send_a(i);
    bus_a.in_valid = 1'b0;
    step();
    check_q_4x4("fresh", 100, 1);

    // Two back-to-back frames with no idle cycle, one pixel per clock
    q_a.delete();
    t0 = cyc;
    for (int i = 0; i < 32; i++) send_a(i);
    check("b2b_cycles", 64'(cyc - t0), 64'd32);
    bus_a.in_valid = 1'b0;
    step();
    step();
    check_q_4x4("b2b", 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
